shift_unit: RTL
===============

// Module: shift_unit
// PURPOSE
//  Execute-stage sequencer wrapped around the combinational 16-bit funnel shifter.
//  Accepts a shift request by valid/ready handshake and drives the shifter's in/mode/n.
//  Captures the shifter output and computes carry, zero and negative flags.
//  Also executes rotate-through-carry (RCR/RCL) iteratively, one bit per cycle.
// PARAMETERS
//  none (datapath fixed at 16 bits; count fixed at 8 bits)
// PORTS
//  clk        in   1   single clock; all state updates on rising edge
//  reset      in   1   synchronous, active-high
//  req_valid  in   1   request present
//  req_ready  out  1   unit can accept (high only in IDLE)
//  req_op     in   4   op[3]=0: shifter mode op[2:0]; 4'b1011 RCR; 4'b1111 RCL; other op[3]=1 = nop
//  req_data   in   16  operand
//  req_count  in   8   shift count 0..255
//  req_cin    in   1   carry in
//  sh_in      out  16  to shifter.in
//  sh_mode    out  3   to shifter.mode
//  sh_n       out  4   to shifter.n
//  sh_out     in   16  from shifter.out (combinational, same cycle)
//  res_valid  out  1   result present
//  res_ready  in   1   consumer takes result
//  res_data   out  16  result
//  res_c      out  1   carry out
//  res_z      out  1   res_data == 0
//  res_n      out  1   res_data[15]
// BEHAVIOUR
//  Reset: state IDLE; res_valid=0, res_data=0, res_c/z/n=0; req_ready=1 the cycle after reset.
//  A reset asserted mid-operation aborts the operation; no result is produced.
//  Shifter ports: sh_mode=3'b000, sh_in=0, sh_n=0 in every state except SHIFT.
//  States: IDLE, SHIFT, RCSTEP, DONE.
//  IDLE: on req_valid&&req_ready, latch op/data/count/cin.
//    Next state is RCSTEP for RCR/RCL with k=count mod 17 != 0, DONE for RCR/RCL with k==0,
//    and SHIFT for every other op.
//  SHIFT, one cycle: sh_in=data, sh_mode=op[2:0] (000 for op[3]=1 nop codes), sh_n=count[3:0].
//    Result registered at the end of the cycle; next state DONE.
//    Latency: accept edge N -> res_valid high after edge N+2.
//  SHIFT result/carry rules (c = count):
//    c==0 or any nop mode: result=data, C=cin.
//    logical R (001), 1..15: sh_out, C=data[c-1]; 16: 0, C=data[15]; >16: 0, C=0.
//    arith R (010), 1..15: sh_out, C=data[c-1]; >=16: {16{data[15]}}, C=data[15].
//    left (101/110 identical), 1..15: sh_out, C=data[16-c]; 16: 0, C=data[0]; >16: 0, C=0.
//    For c>=16 on logical/arith/left the shifter output is ignored.
//    ROR (011), c!=0: sh_out with n=c[3:0], C=result[15]; c mod 16 == 0 gives result=data.
//    ROL (111), c!=0: sh_out with n=c[3:0], C=result[0]; c mod 16 == 0 gives result=data.
//  RCSTEP: 17-bit rotate of {C,data} by one bit per cycle; step counter loaded with k.
//    RCR step: {C,d} <= {d[0], C, d[15:1]}.
//    RCL step: {C,d} <= {d[15], d[14:0], C}.
//    Counter decrements each step; after the k-th step, next state DONE.
//    Latency: k+1 cycles from accept to res_valid.
//  DONE: res_valid=1; res_* held stable until res_ready; on res_valid&&res_ready -> IDLE.
//    req_ready=0 here; no overlap of a new request with a pending result.
//  Flags: Z and N are always computed from the final result; C follows the rules above.
//  An unknown or unused op never produces X on outputs; it behaves as nop.
// TESTING
//  1 data=16'h8001, op=0001, count=1 -> res_data=16'h4000, C=1, Z=0, N=0; valid 2 cycles after accept.
//  2 data=16'h8000, op=0010, count=20 -> res_data=16'hFFFF, C=1, N=1; sh_out ignored.
//  3 data=16'h1234, op=0111, count=4 -> 16'h2341, C=1; same op with count=16 -> 16'h1234, C=0.
//  4 data=16'h0001, cin=0, op=1011, count=1 -> 16'h0000, C=1, Z=1; count=17 -> data, cin, valid 1 cycle after accept.
//  5 data=16'h8000, cin=1, op=1111, count=3 -> 16'h0006, C=0; res_valid asserted 4 cycles after accept.
//  6 hold res_ready=0 for 5 cycles -> res_* stable and req_ready=0; assert reset during RCSTEP -> IDLE, res_valid=0.

Source files
------------

// File: rtl/shift_unit.sv
// Execute-stage sequencer around an external 16-bit funnel shifter. It runs a single-cycle
// shift, or an iterative rotate-through-carry, and returns the result with C/Z/N flags.
module shift_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [15:0] req_data,
    input  logic [7:0]  req_count,
    input  logic        req_cin,
    output logic [15:0] sh_in,
    output logic [2:0]  sh_mode,
    output logic [3:0]  sh_n,
    input  logic [15:0] sh_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_c,
    output logic        res_z,
    output logic        res_n
);

    typedef enum logic [1:0] {IDLE, SHIFT, RCSTEP, DONE} state_t;

    localparam logic [3:0] OP_RCR = 4'b1011;
    localparam logic [3:0] OP_RCL = 4'b1111;

    state_t      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic [15:0] data_q, data_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        c_q, c_d;
    logic        res_valid_q, res_valid_d;
    logic [15:0] res_data_q, res_data_d;
    logic        res_c_q, res_c_d;
    logic        res_z_q, res_z_d;
    logic        res_n_q, res_n_d;

    logic        req_is_rc;
    logic [7:0]  req_k;
    logic [2:0]  mode;
    logic [3:0]  idx_r, idx_l;
    logic [15:0] shift_res;
    logic        shift_c;

    assign req_is_rc = (req_op == OP_RCR) || (req_op == OP_RCL);
    assign req_k     = req_count % 8'd17;
    // op[3]=1 codes reaching SHIFT are nops; they drive the shifter as a pass-through
    assign mode      = op_q[3] ? 3'b000 : op_q[2:0];
    assign idx_r     = cnt_q[3:0] - 4'd1;
    assign idx_l     = 4'(5'd16 - {1'b0, cnt_q[3:0]});

    // Result/carry of the SHIFT cycle; only meaningful while the shifter is driven.
    always_comb begin
        shift_res = data_q;
        shift_c   = c_q;
        if (cnt_q != 8'd0) begin
            case (mode)
                3'b001: begin
                    if (cnt_q < 8'd16) begin
                        shift_res = sh_out;
                        shift_c   = data_q[idx_r];
                    end else begin
                        shift_res = 16'h0000;
                        shift_c   = (cnt_q == 8'd16) ? data_q[15] : 1'b0;
                    end
                end
                3'b010: begin
                    if (cnt_q < 8'd16) begin
                        shift_res = sh_out;
                        shift_c   = data_q[idx_r];
                    end else begin
                        shift_res = {16{data_q[15]}};
                        shift_c   = data_q[15];
                    end
                end
                3'b101, 3'b110: begin
                    if (cnt_q < 8'd16) begin
                        shift_res = sh_out;
                        shift_c   = data_q[idx_l];
                    end else begin
                        shift_res = 16'h0000;
                        shift_c   = (cnt_q == 8'd16) ? data_q[0] : 1'b0;
                    end
                end
                3'b011: begin
                    shift_res = (cnt_q[3:0] == 4'd0) ? data_q : sh_out;
                    shift_c   = shift_res[15];
                end
                3'b111: begin
                    shift_res = (cnt_q[3:0] == 4'd0) ? data_q : sh_out;
                    shift_c   = shift_res[0];
                end
                default: begin
                    shift_res = data_q;
                    shift_c   = c_q;
                end
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        c_d         = c_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_c_d     = res_c_q;
        res_z_d     = res_z_q;
        res_n_d     = res_n_q;
        sh_in       = 16'h0000;
        sh_mode     = 3'b000;
        sh_n        = 4'd0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d   = req_op;
                    data_d = req_data;
                    c_d    = req_cin;
                    if (req_is_rc) begin
                        cnt_d   = req_k;
                        state_d = (req_k == 8'd0) ? DONE : RCSTEP;
                    end else begin
                        cnt_d   = req_count;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                sh_in   = data_q;
                sh_mode = mode;
                sh_n    = cnt_q[3:0];
                data_d  = shift_res;
                c_d     = shift_c;
                state_d = DONE;
            end
            RCSTEP: begin
                if (op_q == OP_RCR)
                    {c_d, data_d} = {data_q[0], c_q, data_q[15:1]};
                else
                    {c_d, data_d} = {data_q[15], data_q[14:0], c_q};
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1)
                    state_d = DONE;
            end
            DONE: begin
                // First DONE cycle publishes the result; outputs then hold until taken
                if (!res_valid_q) begin
                    res_valid_d = 1'b1;
                    res_data_d  = data_q;
                    res_c_d     = c_q;
                    res_z_d     = (data_q == 16'h0000);
                    res_n_d     = data_q[15];
                end else if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= 4'h0;
            data_q      <= 16'h0000;
            cnt_q       <= 8'd0;
            c_q         <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= 16'h0000;
            res_c_q     <= 1'b0;
            res_z_q     <= 1'b0;
            res_n_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            c_q         <= c_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_c_q     <= res_c_d;
            res_z_q     <= res_z_d;
            res_n_q     <= res_n_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_c     = res_c_q;
    assign res_z     = res_z_q;
    assign res_n     = res_n_q;

endmodule
